id_dispatch: RTL and testbench
==============================

# id_dispatch

Decode-stage front end of the core. Accepts fetched instructions from IF over a valid/ready handshake and classifies each one to select its immediate format. Buffers up to two decoded entries and presents the head entry, with its generated immediate, to EX over a second valid/ready handshake. It configures and sequences the `imm_gen` datapath, which it instantiates on its head entry; flush support covers branch redirects.

## Interface
- `DEPTH`, default 2: buffer entries; fixed at 2, no other value supported.
- `clk` input 1: core clock, rising edge.
- `rst` input 1: synchronous reset, active-high.
- `flush_i` input 1: discard all buffered and incoming instructions this cycle.
- `if_valid_i` input 1: IF offers `if_inst_i`/`if_pc_i`.
- `if_ready_o` output 1: block can accept this cycle.
- `if_inst_i` input `RegBus`: raw 32-bit instruction.
- `if_pc_i` input `RegBus`: instruction PC.
- `id_valid_o` output 1: head entry valid.
- `id_ready_i` input 1: EX consumes head this cycle.
- `id_inst_o` output `RegBus`: head instruction.
- `id_pc_o` output `RegBus`: head PC.
- `id_imm_ctrl_o` output `sw_imm_bus`: head immediate select.
- `id_imm_o` output `RegBus`: `imm_gen` output for the head entry.
- `id_ill_o` output 1: head opcode unrecognised.
- `occ_o` output 2: entries held (0..2).

## Operation
- Decode happens on push, from `opcode = inst[6:0]` and `funct3 = inst[14:12]`. The resulting `imm_ctrl` and `ill` are stored with the entry.
  - 0000011 LOAD, 1100111 JALR: `sw_immI`.
  - 0010011 OP-IMM: `sw_immIu` if funct3 = 011 (SLTIU), else `sw_immI`.
  - 0110111 LUI, 0010111 AUIPC: `sw_immU`.
  - 0100011 STORE: `sw_immS`.
  - 1100011 BRANCH: `sw_immBu` if funct3 = 110 or 111 (BLTU/BGEU), else `sw_immB`.
  - 1101111 JAL: `sw_immJ`.
  - 0110011 OP, 1110011 SYSTEM: `sw_immI`, ill = 0; EX ignores the immediate.
  - Any other opcode: `sw_immI`, ill = 1.
- Storage is a 2-entry circular buffer: head/tail pointers (1 bit each, wrap 1 to 0) plus an occupancy counter.
- State machine, by `occ`:
  - EMPTY (0): push goes to ONE.
  - ONE (1): push only goes to FULL; pop only goes to EMPTY; push and pop together stay in ONE, with the new entry becoming head next cycle.
  - FULL (2): pop goes to ONE; push is impossible because ready is 0.
- Handshake rules:
  - push = `if_valid_i & if_ready_o & ~flush_i`.
  - pop = `id_valid_o & id_ready_i & ~flush_i`.
  - `if_ready_o = (occ != 2) & ~rst`, a function of registered state only. There is no combinational path from `id_ready_i`.
  - `id_valid_o = (occ != 0)`.
- While `id_valid_o` = 1 and `id_ready_i` = 0, all `id_*` outputs hold stable.
- `id_imm_o` is combinational through `imm_gen` from the stored head `inst` and `imm_ctrl`.
- Flush: next cycle `occ` = 0 and both pointers = 0. A same-cycle push or pop is ignored. Flush has priority over everything except `rst`.
- Reset values: `occ_o` = 0, `id_valid_o` = 0, `if_ready_o` = 0 while `rst` is high and 1 on the first cycle after. `id_inst_o`, `id_pc_o` = `ZeroWord`; `id_imm_ctrl_o` = `sw_immI`; `id_ill_o` = 0 (storage cleared). Reset mid-operation drops all entries.

## Timing
- Latency: an instruction pushed at edge N is presented with `id_valid_o` = 1 in cycle N+1 if the buffer was empty. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle sustained when `id_ready_i` is held at 1.
- Ready recovery: after a pop from FULL, `if_ready_o` returns at the next cycle.
- Stall behaviour: a stall lasting one cycle with IF streaming causes FULL, then `if_ready_o` = 0 the following cycle.
- Critical path: the `imm_gen` output is not registered, so the head mux feeding `imm_gen` feeds EX combinationally.

## Test plan
- Reset, then push `if_inst_i` = 0xFFF00093 (ADDI x1,x0,-1). Next cycle: `id_valid_o` = 1, `id_imm_ctrl_o` = `sw_immI`, `id_imm_o` = 0xFFFFFFFF, `occ_o` = 1.
- Push 0xFFF03093 (SLTIU). Required: `sw_immIu`, `id_imm_o` = 0x00000FFF. Push BGEU 0xFE00FEE3. Required: `sw_immBu`, `id_imm_o` = 0x00000FFC.
- Hold `id_ready_i` = 0 and push 3 instructions. Required: third push is refused (`if_ready_o` = 0 at `occ_o` = 2) and head outputs stay stable. Release ready: order is preserved across pointer wrap.
- Simultaneous push/pop at `occ_o` = 1 for 10 cycles with a JAL 0x004000EF stream. Required: `occ_o` stays 1, one retirement per cycle, `id_imm_o` = 0x00000004.
- `flush_i` asserted at FULL with a concurrent `if_valid_i`. Next cycle: `occ_o` = 0, `id_valid_o` = 0, the flushed-cycle instruction never appears, `if_ready_o` = 1.
- Push opcode 0x0000007F. Required: `id_ill_o` = 1, `id_imm_ctrl_o` = `sw_immI`. Assert `rst` mid-stream. Required: all outputs at reset values the next cycle.

Source files
------------

// File: rtl/id_dispatch.sv
// Decode-stage front end: classifies fetched instructions by immediate format,
// buffers two decoded entries and presents the head, with its immediate, to EX.

package id_dispatch_pkg;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] SW_IMMI  = 3'd0;
    localparam logic [CTRL_W-1:0] SW_IMMIU = 3'd1;
    localparam logic [CTRL_W-1:0] SW_IMMS  = 3'd2;
    localparam logic [CTRL_W-1:0] SW_IMMB  = 3'd3;
    localparam logic [CTRL_W-1:0] SW_IMMBU = 3'd4;
    localparam logic [CTRL_W-1:0] SW_IMMU  = 3'd5;
    localparam logic [CTRL_W-1:0] SW_IMMJ  = 3'd6;
endpackage

// Immediate generator. The unsigned-compare variants (Iu, Bu) zero-extend the
// low 12 bits so EX can compare against them without further masking.
module imm_gen
    import id_dispatch_pkg::*;
(
    input  logic [31:7]        i_inst,
    input  logic [CTRL_W-1:0]  i_ctrl,
    output logic [DATA_W-1:0]  o_imm
);
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [20:0] w_imm_j;

    assign w_imm_i = i_inst[31:20];
    assign w_imm_s = {i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        o_imm = '0;
        case (i_ctrl)
            SW_IMMI:  o_imm = DATA_W'(w_imm_i);
            SW_IMMIU: o_imm = {20'd0, i_inst[31:20]};
            SW_IMMS:  o_imm = DATA_W'(w_imm_s);
            SW_IMMB:  o_imm = DATA_W'(w_imm_b);
            SW_IMMBU: o_imm = {20'd0, w_imm_b[11:0]};
            SW_IMMU:  o_imm = {i_inst[31:12], 12'd0};
            SW_IMMJ:  o_imm = DATA_W'(w_imm_j);
            default:  o_imm = DATA_W'(w_imm_i);
        endcase
    end
endmodule

module id_dispatch
    import id_dispatch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    input  logic [DATA_W-1:0]  if_inst_i,
    input  logic [DATA_W-1:0]  if_pc_i,
    output logic               id_valid_o,
    input  logic               id_ready_i,
    output logic [DATA_W-1:0]  id_inst_o,
    output logic [DATA_W-1:0]  id_pc_o,
    output logic [CTRL_W-1:0]  id_imm_ctrl_o,
    output logic [DATA_W-1:0]  id_imm_o,
    output logic               id_ill_o,
    output logic [1:0]         occ_o
);
    localparam logic [1:0] LP_FULL = 2'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Returns {ill, imm_ctrl} for one instruction.
    function automatic logic [CTRL_W:0] f_decode(input logic [6:0] opcode,
                                                 input logic [2:0] funct3);
        logic [CTRL_W:0] res;
        res = {1'b0, SW_IMMI};
        case (opcode)
            7'b0000011, 7'b1100111: res = {1'b0, SW_IMMI};
            7'b0010011: res = {1'b0, (funct3 == 3'b011) ? SW_IMMIU : SW_IMMI};
            7'b0110111, 7'b0010111: res = {1'b0, SW_IMMU};
            7'b0100011: res = {1'b0, SW_IMMS};
            7'b1100011: res = {1'b0, (funct3[2:1] == 2'b11) ? SW_IMMBU : SW_IMMB};
            7'b1101111: res = {1'b0, SW_IMMJ};
            7'b0110011, 7'b1110011: res = {1'b0, SW_IMMI};
            default:    res = {1'b1, SW_IMMI};
        endcase
        return res;
    endfunction

    state_t              r_state;
    logic                r_head;
    logic                r_tail;
    logic [DATA_W-1:0]   r_inst [2];
    logic [DATA_W-1:0]   r_pc   [2];
    logic [CTRL_W-1:0]   r_ctrl [2];
    logic                r_ill  [2];

    logic                w_push;
    logic                w_pop;
    logic [CTRL_W:0]     w_dec;

    assign occ_o      = r_state;
    assign if_ready_o = (occ_o != LP_FULL) & ~rst;
    assign id_valid_o = (r_state != ST_EMPTY);

    assign w_push = if_valid_i & if_ready_o & ~flush_i;
    assign w_pop  = id_valid_o & id_ready_i & ~flush_i;
    assign w_dec  = f_decode(if_inst_i[6:0], if_inst_i[14:12]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_inst[i] <= '0;
                r_pc[i]   <= '0;
                r_ctrl[i] <= SW_IMMI;
                r_ill[i]  <= 1'b0;
            end
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) begin
                r_inst[r_tail] <= if_inst_i;
                r_pc[r_tail]   <= if_pc_i;
                r_ctrl[r_tail] <= w_dec[CTRL_W-1:0];
                r_ill[r_tail]  <= w_dec[CTRL_W];
                r_tail         <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      r_state <= ST_FULL;
                    else if (w_pop && !w_push) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_pop) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Head mux feeds EX and imm_gen combinationally; no output register.
    assign id_inst_o     = r_inst[r_head];
    assign id_pc_o       = r_pc[r_head];
    assign id_imm_ctrl_o = r_ctrl[r_head];
    assign id_ill_o      = r_ill[r_head];

    imm_gen u_imm_gen (
        .i_inst (id_inst_o[31:7]),
        .i_ctrl (id_imm_ctrl_o),
        .o_imm  (id_imm_o)
    );
endmodule

// File: tb/tb_id_dispatch.sv
// Directed bench for id_dispatch: per-opcode decode table plus stall, stream,
// flush and reset sequences.

module tb_id_dispatch;
    localparam logic [2:0] C_I  = 3'd0;
    localparam logic [2:0] C_IU = 3'd1;
    localparam logic [2:0] C_S  = 3'd2;
    localparam logic [2:0] C_B  = 3'd3;
    localparam logic [2:0] C_BU = 3'd4;
    localparam logic [2:0] C_U  = 3'd5;
    localparam logic [2:0] C_J  = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_inst_i;
    logic [31:0] if_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [2:0]  id_imm_ctrl_o;
    logic [31:0] id_imm_o;
    logic        id_ill_o;
    logic [1:0]  occ_o;

    int n_cmp  = 0;
    int n_fail = 0;

    id_dispatch #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .if_valid_i    (if_valid_i),
        .if_ready_o    (if_ready_o),
        .if_inst_i     (if_inst_i),
        .if_pc_i       (if_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .id_imm_ctrl_o (id_imm_ctrl_o),
        .id_imm_o      (id_imm_o),
        .id_ill_o      (id_ill_o),
        .occ_o         (occ_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  ctrl;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " occ"},   32'(occ_o), 32'd0);
        chk({tag, " valid"}, 32'(id_valid_o), 32'd0);
        chk({tag, " inst"},  id_inst_o, 32'h0);
        chk({tag, " pc"},    id_pc_o, 32'h0);
        chk({tag, " ctrl"},  32'(id_imm_ctrl_o), 32'(C_I));
        chk({tag, " ill"},   32'(id_ill_o), 32'd0);
        chk({tag, " imm"},   id_imm_o, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hFFF00093, C_I,  32'hFFFFFFFF, 1'b0}; // ADDI x1,x0,-1
        vecs[1]  = '{32'hFFF03093, C_IU, 32'h00000FFF, 1'b0}; // SLTIU
        vecs[2]  = '{32'hFE00FEE3, C_BU, 32'h00000FFC, 1'b0}; // BGEU
        vecs[3]  = '{32'hFE000EE3, C_B,  32'hFFFFFFFC, 1'b0}; // BEQ -4
        vecs[4]  = '{32'h004000EF, C_J,  32'h00000004, 1'b0}; // JAL +4
        vecs[5]  = '{32'h12345037, C_U,  32'h12345000, 1'b0}; // LUI
        vecs[6]  = '{32'h00001097, C_U,  32'h00001000, 1'b0}; // AUIPC
        vecs[7]  = '{32'hFE112E23, C_S,  32'hFFFFFFFC, 1'b0}; // SW x1,-4(x2)
        vecs[8]  = '{32'h000080E7, C_I,  32'h00000000, 1'b0}; // JALR
        vecs[9]  = '{32'h002081B3, C_I,  32'h00000002, 1'b0}; // ADD
        vecs[10] = '{32'h0000007F, C_I,  32'h00000000, 1'b1}; // unknown opcode

        rst = 1'b1; flush_i = 1'b0; if_valid_i = 1'b0; id_ready_i = 1'b0;
        if_inst_i = 32'h0; if_pc_i = 32'h0;
        step();
        step();
        chk("rst ready", 32'(if_ready_o), 32'd0);
        chk_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("post-rst ready", 32'(if_ready_o), 32'd1);

        // Decode table: push into empty buffer, inspect head, pop.
        for (int i = 0; i < 11; i++) begin
            if_inst_i = vecs[i].inst; if_pc_i = 32'h1000 + 32'(i * 4);
            if_valid_i = 1'b1; id_ready_i = 1'b0;
            chk($sformatf("v%0d ready", i), 32'(if_ready_o), 32'd1);
            step();
            if_valid_i = 1'b0;
            chk($sformatf("v%0d valid", i), 32'(id_valid_o), 32'd1);
            chk($sformatf("v%0d occ", i),   32'(occ_o), 32'd1);
            chk($sformatf("v%0d inst", i),  id_inst_o, vecs[i].inst);
            chk($sformatf("v%0d pc", i),    id_pc_o, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d ctrl", i),  32'(id_imm_ctrl_o), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d imm", i),   id_imm_o, vecs[i].imm);
            chk($sformatf("v%0d ill", i),   32'(id_ill_o), 32'(vecs[i].ill));
            id_ready_i = 1'b1;
            step();
            id_ready_i = 1'b0;
            chk($sformatf("v%0d drained", i), 32'(occ_o), 32'd0);
        end

        // Stall: third push refused, head stable, order kept across wrap.
        if_valid_i = 1'b1; id_ready_i = 1'b0;
        if_inst_i = vecs[0].inst; if_pc_i = 32'h2000;
        step();
        if_inst_i = vecs[1].inst; if_pc_i = 32'h2004;
        step();
        if_inst_i = vecs[2].inst; if_pc_i = 32'h2008;
        chk("full ready", 32'(if_ready_o), 32'd0);
        chk("full occ",   32'(occ_o), 32'd2);
        chk("full head",  id_inst_o, vecs[0].inst);
        step();
        chk("stall occ",  32'(occ_o), 32'd2);
        chk("stall head", id_inst_o, vecs[0].inst);
        chk("stall pc",   id_pc_o, 32'h2000);
        chk("stall imm",  id_imm_o, vecs[0].imm);
        id_ready_i = 1'b1;
        step();
        chk("pop1 occ",   32'(occ_o), 32'd1);
        chk("pop1 ready", 32'(if_ready_o), 32'd1);
        chk("pop1 head",  id_inst_o, vecs[1].inst);
        chk("pop1 imm",   id_imm_o, vecs[1].imm);
        step();
        if_valid_i = 1'b0;
        chk("wrap occ",   32'(occ_o), 32'd1);
        chk("wrap head",  id_inst_o, vecs[2].inst);
        chk("wrap pc",    id_pc_o, 32'h2008);
        chk("wrap imm",   id_imm_o, vecs[2].imm);
        step();
        id_ready_i = 1'b0;
        chk("stall drained", 32'(occ_o), 32'd0);

        // Sustained push+pop at occ 1 with a JAL stream.
        if_valid_i = 1'b1; if_inst_i = 32'h004000EF; if_pc_i = 32'h3000;
        step();
        id_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_pc_i = 32'h3000 + 32'((i + 1) * 4);
            chk($sformatf("jal%0d occ", i), 32'(occ_o), 32'd1);
            chk($sformatf("jal%0d pc", i),  id_pc_o, 32'h3000 + 32'(i * 4));
            chk($sformatf("jal%0d imm", i), id_imm_o, 32'h00000004);
            step();
        end
        if_valid_i = 1'b0;
        chk("jal last pc", id_pc_o, 32'h3028);
        step();
        id_ready_i = 1'b0;
        chk("jal drained", 32'(occ_o), 32'd0);

        // Flush at FULL with IF still offering.
        if_valid_i = 1'b1; if_inst_i = vecs[5].inst; if_pc_i = 32'h4000;
        step();
        if_pc_i = 32'h4004;
        step();
        chk("pre-flush occ", 32'(occ_o), 32'd2);
        flush_i = 1'b1; if_inst_i = vecs[6].inst; if_pc_i = 32'h4008;
        step();
        flush_i = 1'b0; if_valid_i = 1'b0;
        chk("flush occ",   32'(occ_o), 32'd0);
        chk("flush valid", 32'(id_valid_o), 32'd0);
        chk("flush ready", 32'(if_ready_o), 32'd1);
        step();
        chk("flush no ghost", 32'(occ_o), 32'd0);

        // Flush at ONE: concurrent push and pop both ignored.
        if_valid_i = 1'b1; if_inst_i = vecs[7].inst; if_pc_i = 32'h5000;
        step();
        flush_i = 1'b1; id_ready_i = 1'b1; if_pc_i = 32'h5004;
        step();
        flush_i = 1'b0; id_ready_i = 1'b0; if_valid_i = 1'b0;
        chk("flush1 occ", 32'(occ_o), 32'd0);
        if_valid_i = 1'b1; if_inst_i = vecs[9].inst; if_pc_i = 32'h5008;
        step();
        if_valid_i = 1'b0;
        chk("post-flush head", id_inst_o, vecs[9].inst);
        chk("post-flush pc",   id_pc_o, 32'h5008);
        id_ready_i = 1'b1;
        step();
        id_ready_i = 1'b0;

        // Illegal opcode, then reset mid-stream.
        if_valid_i = 1'b1; if_inst_i = 32'h0000007F; if_pc_i = 32'h6000;
        step();
        if_inst_i = vecs[5].inst; if_pc_i = 32'h6004;
        chk("ill flag", 32'(id_ill_o), 32'd1);
        chk("ill ctrl", 32'(id_imm_ctrl_o), 32'(C_I));
        step();
        chk("pre-rst occ", 32'(occ_o), 32'd2);
        rst = 1'b1;
        step();
        chk("midrst ready", 32'(if_ready_o), 32'd0);
        chk_reset_outputs("midrst");
        rst = 1'b0; if_valid_i = 1'b0;
        #1;
        chk("midrst recover ready", 32'(if_ready_o), 32'd1);
        step();
        chk("midrst idle occ", 32'(occ_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
